calc_port_responder: RTL and testbench

Synthesizable single-port responder for the calc1 request/response protocol: samples a command and first operand, then a second operand one cycle later, executes add/subtract/shift, and returns a one-cycle response code with result data. It is the design-side counterpart of the port-driving benches and the building block for a multi-port calculator (one instance per port, four per calc1-style top). A one-entry pending buffer absorbs a back-to-back request arriving while an operation is in flight.

---
 rtl/calc_port_responder.sv | 161 ++++++++++++++++
 tb/tb_calc_port_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_responder.sv
// calc1 single-port responder: add/sub/shift with a one-entry pending slot.
// Optional shifter enabled by defining CALC_RESP_SHIFT_EN.
module calc_port_responder #(
  parameter int LATENCY = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, OPND2, EXEC, RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [3:0]  cnt_q;
  logic [33:0] res_q;
  logic [1:0]  resp_q;
  logic [31:0] data_q;

  logic        pend_v_q;
  logic        pend_ph_q;
  logic [3:0]  pend_cmd_q;
  logic [31:0] pend_op1_q;
  logic [31:0] pend_op2_q;

  logic [31:0] pend_op2_d;
  logic [33:0] res_d;

  // Packs {resp, data}; data is forced to 0 unless resp is success.
  function automatic logic [33:0] calc(
    input logic [3:0]  cmd,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] sum;
    logic [1:0]  r;
    logic [31:0] d;
    sum = {1'b0, a} + {1'b0, b};
    r = 2'd2;
    d = '0;
    unique case (1'b1)
      (cmd == 4'd1): begin
        if (!sum[32]) begin
          r = 2'd1;
          d = sum[31:0];
        end
      end
      (cmd == 4'd2): begin
        if (b <= a) begin
          r = 2'd1;
          d = a - b;
        end
      end
`ifdef CALC_RESP_SHIFT_EN
      (cmd == 4'd5): begin
        r = 2'd1;
        d = a << b[4:0];
      end
      (cmd == 4'd6): begin
        r = 2'd1;
        d = a >> b[4:0];
      end
`endif
      default: ;
    endcase
    return {r, d};
  endfunction

  // Pending op2 may still be on the bus when RESP promotes the slot.
  always_comb begin
    pend_op2_d = pend_ph_q ? req_data_in : pend_op2_q;
    res_d = '0;
    if (state_q == OPND2) begin
      res_d = calc(cmd_q, op1_q, req_data_in);
    end else begin
      res_d = calc(pend_cmd_q, pend_op1_q, pend_op2_d);
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      resp_q     <= '0;
      data_q     <= '0;
      pend_v_q   <= 1'b0;
      pend_ph_q  <= 1'b0;
      pend_cmd_q <= '0;
      pend_op1_q <= '0;
      pend_op2_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_cmd_in != '0) begin
            cmd_q   <= req_cmd_in;
            op1_q   <= req_data_in;
            state_q <= OPND2;
          end
        end
        OPND2: begin
          res_q   <= res_d;
          cnt_q   <= CNT_LOAD;
          state_q <= EXEC;
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            resp_q  <= res_q[33:32];
            data_q  <= res_q[31:0];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
          if (pend_ph_q) begin
            pend_op2_q <= req_data_in;
            pend_ph_q  <= 1'b0;
          end else if (!pend_v_q && req_cmd_in != '0) begin
            pend_v_q   <= 1'b1;
            pend_ph_q  <= 1'b1;
            pend_cmd_q <= req_cmd_in;
            pend_op1_q <= req_data_in;
          end
        end
        RESP: begin
          resp_q <= '0;
          data_q <= '0;
          if (pend_v_q) begin
            res_q     <= res_d;
            cnt_q     <= CNT_LOAD;
            state_q   <= EXEC;
            pend_v_q  <= 1'b0;
            pend_ph_q <= 1'b0;
          end else if (req_cmd_in != '0) begin
            cmd_q   <= req_cmd_in;
            op1_q   <= req_data_in;
            state_q <= OPND2;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign busy     = (state_q != IDLE) || pend_v_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed self-checking bench for calc_port_responder.
// Shift expectations follow CALC_RESP_SHIFT_EN.
module tb_calc_port_responder;

  localparam int LAT = 2;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int checks;
  int errors;

  calc_port_responder #(.LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic issue(
    input logic [3:0]  cmd,
    input logic [31:0] a,
    input logic [31:0] b
  );
    req_cmd_in  = cmd;
    req_data_in = a;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = b;
    tick();
    req_data_in = '0;
  endtask

  task automatic wait_resp(
    output logic [1:0]  r,
    output logic [31:0] d,
    output int          n
  );
    n = 0;
    while (out_resp == 2'd0 && n < 20) begin
      tick();
      n++;
    end
    r = out_resp;
    d = out_data;
  endtask

  task automatic exec_op(
    input  logic [3:0]  cmd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [1:0]  r,
    output logic [31:0] d,
    output int          n,
    output logic [1:0]  after
  );
    issue(cmd, a, b);
    wait_resp(r, d, n);
    tick();
    after = out_resp;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    repeat (3) tick();
    checks++;
    if (out_resp !== 2'd0 || out_data !== 32'd0
        || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: resp=%0d data=%h busy=%b want 0 0 0",
               out_resp, out_data, busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add_basic();
    logic [1:0]  r;
    logic [31:0] d;
    int          n;
    req_cmd_in  = 4'd1;
    req_data_in = 32'd1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%b want 1", busy);
    end
    req_cmd_in  = 4'd0;
    req_data_in = 32'h14FF_FFFE;
    tick();
    req_data_in = '0;
    wait_resp(r, d, n);
    checks++;
    if (r !== 2'd1 || d !== 32'h14FF_FFFF) begin
      errors++;
      $display("FAIL add_basic: resp=%0d data=%h want 1 14ffffff",
               r, d);
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL add_latency: cycles=%0d want %0d", n, LAT);
    end
    tick();
    checks++;
    if (out_resp !== 2'd0 || out_data !== 32'd0
        || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_one_cycle: resp=%0d data=%h busy=%b want 0",
               out_resp, out_data, busy);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  af;
    int          n;
    exec_op(4'd1, 32'hF000_0000, 32'hF000_0000, r, d, n, af);
    checks++;
    if (r !== 2'd2 || d !== 32'd0) begin
      errors++;
      $display("FAIL add_ovf: resp=%0d data=%h want 2 0", r, d);
    end
    exec_op(4'd1, 32'd0, 32'd0, r, d, n, af);
    checks++;
    if (r !== 2'd1 || d !== 32'd0) begin
      errors++;
      $display("FAIL add_zero: resp=%0d data=%h want 1 0", r, d);
    end
    exec_op(4'd2, 32'd5, 32'd8, r, d, n, af);
    checks++;
    if (r !== 2'd2 || d !== 32'd0) begin
      errors++;
      $display("FAIL sub_under: resp=%0d data=%h want 2 0", r, d);
    end
    exec_op(4'd2, 32'd8, 32'd5, r, d, n, af);
    checks++;
    if (r !== 2'd1 || d !== 32'd3) begin
      errors++;
      $display("FAIL sub_ok: resp=%0d data=%h want 1 3", r, d);
    end
    exec_op(4'd2, 32'd7, 32'd7, r, d, n, af);
    checks++;
    if (r !== 2'd1 || d !== 32'd0) begin
      errors++;
      $display("FAIL sub_equal: resp=%0d data=%h want 1 0", r, d);
    end
    exec_op(4'd3, 32'd9, 32'd1, r, d, n, af);
    checks++;
    if (r !== 2'd2 || d !== 32'd0 || n !== LAT) begin
      errors++;
      $display("FAIL invalid3: resp=%0d data=%h lat=%0d want 2 0 %0d",
               r, d, n, LAT);
    end
    exec_op(4'd15, 32'd9, 32'd1, r, d, n, af);
    checks++;
    if (r !== 2'd2 || d !== 32'd0 || af !== 2'd0) begin
      errors++;
      $display("FAIL invalid15: resp=%0d data=%h next=%0d want 2 0 0",
               r, d, af);
    end
  endtask

  task automatic test_shift();
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  af;
    int          n;
    logic [1:0]  er;
    logic [31:0] el;
    logic [31:0] erd;
`ifdef CALC_RESP_SHIFT_EN
    er  = 2'd1;
    el  = 32'd2;
    erd = 32'd1;
`else
    er  = 2'd2;
    el  = 32'd0;
    erd = 32'd0;
`endif
    exec_op(4'd5, 32'd1, 32'hFFFF_FFE1, r, d, n, af);
    checks++;
    if (r !== er || d !== el || n !== LAT) begin
      errors++;
      $display("FAIL shl: resp=%0d data=%h lat=%0d want %0d %h %0d",
               r, d, n, er, el, LAT);
    end
    exec_op(4'd6, 32'h8000_0000, 32'd31, r, d, n, af);
    checks++;
    if (r !== er || d !== erd) begin
      errors++;
      $display("FAIL shr: resp=%0d data=%h want %0d %h",
               r, d, er, erd);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    issue(4'd1, 32'd1, 32'd1);
    req_cmd_in  = 4'd1;
    req_data_in = 32'd2;
    tick();
    checks++;
    if (out_resp !== 2'd0) begin
      errors++;
      $display("FAIL b2b_early: resp=%0d want 0", out_resp);
    end
    req_cmd_in  = 4'd1;
    req_data_in = 32'd2;
    tick();
    checks++;
    if (out_resp !== 2'd1 || out_data !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: resp=%0d data=%h want 1 2",
               out_resp, out_data);
    end
    req_cmd_in  = 4'd0;
    req_data_in = 32'd99;
    tick();
    req_data_in = '0;
    checks++;
    if (out_resp !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: resp=%0d busy=%b want 0 1",
               out_resp, busy);
    end
    tick();
    checks++;
    if (out_resp !== 2'd0) begin
      errors++;
      $display("FAIL b2b_gap2: resp=%0d want 0", out_resp);
    end
    tick();
    checks++;
    if (out_resp !== 2'd1 || out_data !== 32'd4) begin
      errors++;
      $display("FAIL b2b_second: resp=%0d data=%h want 1 4",
               out_resp, out_data);
    end
    tick();
    checks++;
    if (out_resp !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: resp=%0d busy=%b want 0 0",
               out_resp, busy);
    end
    extra = 0;
    repeat (10) begin
      tick();
      if (out_resp != 2'd0 || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_dropped: late_cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  af;
    int          n;
    int          late;
    issue(4'd1, 32'd10, 32'd20);
    reset = 1'b0;
    tick();
    checks++;
    if (out_resp !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: resp=%0d busy=%b want 0 0",
               out_resp, busy);
    end
    reset = 1'b1;
    late = 0;
    repeat (20) begin
      tick();
      if (out_resp != 2'd0) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL rst_late: resp_cycles=%0d want 0", late);
    end
    exec_op(4'd1, 32'd3, 32'd4, r, d, n, af);
    checks++;
    if (r !== 2'd1 || d !== 32'd7) begin
      errors++;
      $display("FAIL rst_recover: resp=%0d data=%h want 1 7", r, d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_basic();
    test_arith();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
